// File: rtl/sqwave_meter.sv
// sqwave_meter: measures high/low phase durations of a square wave in
// TICKS_PER_UNIT-cycle units, publishes them as 4-bit m/n values, and
// flags a stuck input and phases that exceed the 4-bit range.
module sqwave_meter #(
  parameter int unsigned TICKS_PER_UNIT = 5,
  parameter int unsigned TIMEOUT_UNITS  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sq_in,
  output logic [3:0] m_meas,
  output logic [3:0] n_meas,
  output logic       meas_valid,
  output logic       ovf,
  output logic       stuck,
  output logic       stuck_level
);

  localparam int unsigned TW = (TICKS_PER_UNIT > 2) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_UNIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'((TICKS_PER_UNIT + 1) / 2);
  localparam logic [5:0] TMO_UNITS = 6'(TIMEOUT_UNITS);
  localparam logic [6:0] MAX_4B = 7'd15;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  logic          sync1_q, sq_s_q, sq_d_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    unit_q, unit_d;
  state_e        state_q, state_d;
  logic [6:0]    hi_q, hi_d;
  logic [3:0]    m_q, m_d, n_q, n_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          stuck_q, stuck_d;
  logic          lvl_q, lvl_d;

  logic          rise, fall, edge_det, timeout;
  logic [6:0]    phase;

  assign rise     = sq_s_q & ~sq_d_q;
  assign fall     = ~sq_s_q & sq_d_q;
  assign edge_det = rise | fall;
  // Rounded phase length of the phase that the current edge terminates.
  assign phase    = {1'b0, unit_q} + 7'(tick_q >= TICK_HALF);
  // An edge resets the unit counter, so it wins over a coincident timeout.
  assign timeout  = ~edge_det && (unit_q >= TMO_UNITS);

  // Input synchronizer and one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sq_s_q  <= 1'b0;
      sq_d_q  <= 1'b0;
    end else begin
      sync1_q <= sq_in;
      sq_s_q  <= sync1_q;
      sq_d_q  <= sq_s_q;
    end
  end

  // Phase counter: sub-unit ticks plus saturating unit count; edge restarts it.
  always_comb begin
    tick_d = tick_q;
    unit_d = unit_q;
    if (edge_det) begin
      tick_d = TW'(1);
      unit_d = '0;
    end else if (tick_q == TICK_MAX) begin
      tick_d = '0;
      unit_d = (unit_q == 6'd63) ? unit_q : unit_q + 6'd1;
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  // FSM next state, phase latching, publish step and stuck detection.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    m_d     = m_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    stuck_d = stuck_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          hi_d    = phase;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          m_d     = (hi_q > MAX_4B) ? 4'hF : hi_q[3:0];
          n_d     = (phase > MAX_4B) ? 4'hF : phase[3:0];
          ovf_d   = (hi_q > MAX_4B) || (phase > MAX_4B);
          valid_d = 1'b1;
          state_d = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (edge_det) stuck_d = 1'b0;
    if (timeout) begin
      stuck_d = 1'b1;
      lvl_d   = sq_s_q;
      state_d = IDLE;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= '0;
      unit_q  <= '0;
      state_q <= IDLE;
      hi_q    <= '0;
      m_q     <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      state_q <= state_d;
      hi_q    <= hi_d;
      m_q     <= m_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      lvl_q   <= lvl_d;
    end
  end

  assign m_meas      = m_q;
  assign n_meas      = n_q;
  assign meas_valid  = valid_q;
  assign ovf         = ovf_q;
  assign stuck       = stuck_q;
  assign stuck_level = lvl_q;

endmodule

// File: doc/sqwave_meter.md
Name: sqwave_meter

Overview:
Downstream monitor for the programmable square-wave generator. It measures the high and low phase durations of a square wave in 100 ns units (5 clk cycles at 50 MHz) and reports them as 4-bit m/n values. It flags a stuck (constant) output and out-of-range phases. It is used on-board to close the loop on the generator's m/n settings.

Parameters:
TICKS_PER_UNIT, 5, clk cycles per 100 ns unit (min 2)
TIMEOUT_UNITS, 32, units without an edge before stuck is declared (≤ 63)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
sq_in  in  1  square wave under test; may be asynchronous
m_meas  out  4  last measured high duration, in units
n_meas  out  4  last measured low duration, in units
meas_valid  out  1  one-cycle pulse when m_meas/n_meas update
ovf  out  1  last published measurement had a phase > 15 units
stuck  out  1  no edge for TIMEOUT_UNITS
stuck_level  out  1  synchronized level of sq_in while stuck

Behaviour:
- Reset (async, rst=1): all outputs, sync flops, counters = 0; state = IDLE.
- Input synchronizer: 2-flop synchronizer on sq_in gives sq_s. Edge detect compares sq_s with its 1-cycle delayed copy sq_d.
  - rise = sq_s & ~sq_d; fall = ~sq_s & sq_d.
  - Total input-to-detect latency: 2 cycles plus the detect cycle.
- Phase counter (runs in all states):
  - tick_cnt: 0..TICKS_PER_UNIT-1. unit_cnt: 6 bits, saturating at 63.
  - On any edge: tick_cnt <= 1, unit_cnt <= 0. The edge cycle counts as cycle 1 of the new phase.
  - Otherwise, tick_cnt increments. When tick_cnt == TICKS_PER_UNIT-1, tick_cnt <= 0 and unit_cnt increments (saturating).
  - Phase value at the terminating edge, before the reset above: units = unit_cnt + (tick_cnt ≥ ceil(TICKS_PER_UNIT/2) ? 1 : 0). This rounds to the nearest unit; for TICKS_PER_UNIT=5 the threshold is 3.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise go to HIGH. Fall is ignored, so the first period is never partial.
  - HIGH: on fall, latch hi_units = phase value and go to LOW.
  - LOW: on rise, perform the publish step below, then go to HIGH.
  - Publish step: latch lo_units = phase value; m_meas <= min(hi_units, 15); n_meas <= min(lo_units, 15); ovf <= (hi_units > 15 | lo_units > 15); meas_valid = 1 for exactly that cycle.
  - The first meas_valid occurs one full period after the first rise.
- Timeout:
  - When unit_cnt reaches TIMEOUT_UNITS without an edge (any state): stuck <= 1, stuck_level <= sq_s, state <= IDLE.
  - m_meas, n_meas and ovf hold their values.
  - stuck clears on the next edge. If that edge is a rise, IDLE→HIGH proceeds in the same cycle.
- Simultaneous events:
  - An edge in the same cycle that the timeout would fire takes priority; stuck is not set.
  - meas_valid and the stuck clear can coincide only on a rise in LOW, which cannot happen while stuck (state is IDLE).
- Reset mid-measurement: outputs return to 0 immediately (async). The first valid after release requires a full new period.
- Output signals are registered, with no combinational path from sq_in.

Test Plan:
1. Generator-equivalent wave, high 15 cycles / low 10 cycles, repeating → meas_valid every 25 cycles, m_meas=3, n_meas=2, ovf=0, stuck=0. The first valid arrives 25 cycles after the first detected rise.
2. High 75 / low 5 (m=15, n=1) → m_meas=15, n_meas=1, ovf=0. Then high 100 cycles (20 units) → m_meas=15, ovf=1 on that valid, ovf=0 on the next legal period.
3. Rounding: high 13 cycles, low 17 cycles → m_meas=3, n_meas=3. High 12, low 7 → m_meas=2, n_meas=1.
4. sq_in held 0 after reset → stuck=1, stuck_level=0 once unit_cnt reaches 32 (160 counted cycles), meas_valid never pulses. Then drive the 15/10 wave → stuck clears on the first detected rise and valid resumes one period later. Repeat with sq_in held 1 → stuck_level=1.
5. Assert rst for 1 cycle while in LOW mid-period → all outputs 0 asynchronously, state IDLE. No meas_valid until one full period after the next rise.
6. Change the wave from 15/10 to 5/40 mid-stream → one valid may mix the old and new phase (m=3, n=8), then steady m_meas=1, n_meas=8.
